// File: rtl/dircc_types_pkg.sv
// Shared packet and address types for the dircc Avalon-ST packet path.
// One packet travels as PACKET_BEATS 32-bit beats.
package dircc_types_pkg;

  localparam int PACKET_BEATS = 8;

  // The upper 24 bits of an address beat carry {sw_addr, port, flag}
  typedef struct packed {
    logic [31:0] hw_addr;
    logic [15:0] sw_addr;
    logic [6:0]  port;
    logic        flag;
  } address_t;

  typedef struct packed {
    address_t    dest_addr;
    address_t    src_addr;
    logic [31:0] lamport;
    logic [95:0] data;
  } packet_t;

  function automatic address_t with_upper(input address_t addr, input logic [23:0] upper);
    address_t result;
    result = addr;
    {result.sw_addr, result.port, result.flag} = upper;
    return result;
  endfunction

endpackage

// File: rtl/dircc_avalon_st_packet_receiver.sv
// Reassembles 8-beat Avalon-ST frames into a packet_t; packet_valid rises 1 cycle after the eop beat.
// ready drops while an unread packet is held, so the sink stalls until read_packet.
module dircc_avalon_st_packet_receiver
  import dircc_types_pkg::*;
#(
  parameter int  BITS_PER_SYMBOL  = 8,
  parameter int  SYMBOLS_PER_BEAT = 4,
  localparam int DATA_WIDTH       = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  localparam int EMPTY_WIDTH      = (SYMBOLS_PER_BEAT > 1) ? $clog2(SYMBOLS_PER_BEAT) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [EMPTY_WIDTH-1:0] empty,
  input  logic                   startofpacket,
  input  logic                   endofpacket,
  input  logic                   valid,
  output logic                   ready,
  output packet_t                packet_data,
  output logic                   packet_valid,
  input  logic                   read_packet,
  output logic                   receiving,
  output logic                   error,
  output logic [7:0]             error_count
);

  // Declaration order follows beat order so a capture state advances by +1
  typedef enum logic [3:0] {
    IDLE,
    DEST_ADDR1,
    SRC_ADDR0,
    SRC_ADDR1,
    LAMPORT,
    DATA0,
    DATA1,
    DATA2,
    DISCARD
  } state_t;

  state_t      state;
  state_t      state_next;
  packet_t     shadow;
  packet_t     commit_pkt;
  logic [31:0] beat;
  logic        accept;
  logic        load_beat0;
  logic        store;
  logic        commit;
  logic        frame_err;
  logic        unused_empty;

  assign unused_empty = ^empty;
  assign beat         = data[31:0];
  assign ready        = reset_n && !packet_valid;
  assign accept       = valid && ready;
  assign receiving    = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_beat0 = 1'b0;
    store      = 1'b0;
    commit     = 1'b0;
    frame_err  = 1'b0;
    if (accept) begin
      if (startofpacket) begin
        // A fresh sop always wins; one-beat frames and mid-frame restarts are errors
        frame_err = ((state != IDLE) && (state != DISCARD)) || endofpacket;
        if (endofpacket) begin
          state_next = IDLE;
        end else begin
          load_beat0 = 1'b1;
          state_next = DEST_ADDR1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            frame_err = 1'b1;
          end
          DATA2: begin
            if (endofpacket) begin
              commit     = 1'b1;
              state_next = IDLE;
            end else begin
              frame_err  = 1'b1;
              state_next = DISCARD;
            end
          end
          DISCARD: begin
            if (endofpacket) begin
              state_next = IDLE;
            end
          end
          default: begin
            if (endofpacket) begin
              frame_err  = 1'b1;
              state_next = IDLE;
            end else begin
              store      = 1'b1;
              state_next = state_t'(state + 4'd1);
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    commit_pkt              = shadow;
    commit_pkt.data[95:64]  = beat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow       <= '0;
      packet_data  <= '0;
      packet_valid <= 1'b0;
      error        <= 1'b0;
      error_count  <= 8'd0;
    end else begin
      error <= frame_err;
      if (frame_err && (error_count != 8'hff)) begin
        error_count <= error_count + 8'd1;
      end

      if (commit) begin
        packet_data  <= commit_pkt;
        packet_valid <= 1'b1;
      end else if (read_packet) begin
        packet_valid <= 1'b0;
      end

      if (load_beat0) begin
        shadow.dest_addr.hw_addr <= beat;
      end else if (store) begin
        unique case (state)
          DEST_ADDR1: shadow.dest_addr         <= with_upper(shadow.dest_addr, beat[31:8]);
          SRC_ADDR0:  shadow.src_addr.hw_addr  <= beat;
          SRC_ADDR1:  shadow.src_addr          <= with_upper(shadow.src_addr, beat[31:8]);
          LAMPORT:    shadow.lamport           <= beat;
          DATA0:      shadow.data[31:0]        <= beat;
          DATA1:      shadow.data[63:32]       <= beat;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dircc_avalon_st_packet_receiver.sv
// Randomized and directed bench for dircc_avalon_st_packet_receiver against a beat-queue reference model.
module tb_dircc_avalon_st_packet_receiver;
  import dircc_types_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] data = '0;
  logic [1:0]  empty = '0;
  logic        startofpacket = 1'b0;
  logic        endofpacket = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  packet_t     packet_data;
  logic        packet_valid;
  logic        read_packet = 1'b0;
  logic        receiving;
  logic        error;
  logic [7:0]  error_count;

  dircc_avalon_st_packet_receiver dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data          (data),
    .empty         (empty),
    .startofpacket (startofpacket),
    .endofpacket   (endofpacket),
    .valid         (valid),
    .ready         (ready),
    .packet_data   (packet_data),
    .packet_valid  (packet_valid),
    .read_packet   (read_packet),
    .receiving     (receiving),
    .error         (error),
    .error_count   (error_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: beats of the frame in progress, discard flag, output register
  logic [31:0] m_cur[$];
  bit          m_disc = 0;
  bit          m_pv = 0;
  bit          m_err = 0;
  int          m_cnt = 0;
  packet_t     m_pkt = '0;

  bit          gaps = 0;
  bit          rand_read = 0;
  logic [31:0] words[16];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic packet_t build(input logic [31:0] w0, input logic [31:0] w1,
                                    input logic [31:0] w2, input logic [31:0] w3,
                                    input logic [31:0] w4, input logic [31:0] w5,
                                    input logic [31:0] w6, input logic [31:0] w7);
    packet_t p;
    p.dest_addr.hw_addr = w0;
    p.dest_addr.sw_addr = 16'(w1 >> 16);
    p.dest_addr.port    = 7'((w1 >> 9) & 32'h7f);
    p.dest_addr.flag    = w1[8];
    p.src_addr.hw_addr  = w2;
    p.src_addr.sw_addr  = 16'(w3 >> 16);
    p.src_addr.port     = 7'((w3 >> 9) & 32'h7f);
    p.src_addr.flag     = w3[8];
    p.lamport           = w4;
    p.data              = {w7, w6, w5};
    return p;
  endfunction

  task automatic model_reset();
    m_cur.delete();
    m_disc = 0;
    m_pv   = 0;
    m_err  = 0;
    m_cnt  = 0;
    m_pkt  = '0;
  endtask

  task automatic model_beat(input logic [31:0] d, input logic s, input logic e,
                            output bit ferr, output bit cmt, output packet_t p);
    ferr = 0;
    cmt  = 0;
    p    = '0;
    if (s) begin
      if (m_cur.size() != 0 || e) ferr = 1;
      m_cur.delete();
      m_disc = 0;
      if (!e) m_cur.push_back(d);
    end else if (m_disc) begin
      if (e) m_disc = 0;
    end else if (m_cur.size() == 0) begin
      ferr = 1;
    end else if (m_cur.size() < PACKET_BEATS - 1) begin
      if (e) begin
        ferr = 1;
        m_cur.delete();
      end else begin
        m_cur.push_back(d);
      end
    end else begin
      if (e) begin
        cmt = 1;
        p = build(m_cur[0], m_cur[1], m_cur[2], m_cur[3], m_cur[4], m_cur[5], m_cur[6], d);
      end else begin
        ferr = 1;
        m_disc = 1;
      end
      m_cur.delete();
    end
  endtask

  task automatic compare_all();
    check("ready", 256'(ready), 256'(reset_n && !m_pv));
    check("packet_valid", 256'(packet_valid), 256'(m_pv));
    check("error", 256'(error), 256'(m_err));
    check("error_count", 256'(error_count), 256'(m_cnt));
    check("receiving", 256'(receiving), 256'(m_cur.size() != 0 || m_disc));
    check("packet_data", 256'(packet_data), 256'(m_pkt));
  endtask

  // One clock: predict from pre-edge inputs, advance model at the edge, compare 1 ns later
  task automatic cycle();
    bit      acc;
    bit      ferr;
    bit      cmt;
    packet_t p;
    acc  = valid && reset_n && !m_pv;
    ferr = 0;
    cmt  = 0;
    p    = '0;
    if (acc) model_beat(data, startofpacket, endofpacket, ferr, cmt, p);
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      m_err = ferr;
      if (ferr && m_cnt != 255) m_cnt++;
      if (read_packet && m_pv) m_pv = 0;
      if (cmt) begin
        m_pv  = 1;
        m_pkt = p;
      end
    end
    #1;
    compare_all();
  endtask

  task automatic send_beat(input logic [31:0] d, input logic s, input logic e);
    bit done = 0;
    int waited = 0;
    while (!done) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        valid = 1'b0;
      end else begin
        valid = 1'b1;
        data = d;
        startofpacket = s;
        endofpacket = e;
        empty = 2'($urandom);
      end
      read_packet = rand_read ? ($urandom_range(0, 2) == 0) : 1'b0;
      done = valid && reset_n && !m_pv;
      cycle();
      waited++;
      if (!done && waited > 200) begin
        check("accept_timeout", 256'(waited), 256'(200));
        done = 1;
      end
    end
    valid = 1'b0;
    startofpacket = 1'b0;
    endofpacket = 1'b0;
    read_packet = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [15:0] sop_mask, input logic [15:0] eop_mask);
    for (int i = 0; i < n; i++) send_beat(words[i], sop_mask[i], eop_mask[i]);
  endtask

  task automatic read_pkt();
    read_packet = 1'b1;
    cycle();
    read_packet = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    valid = 1'b0;
    read_packet = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic load_golden();
    words[0] = 32'h00000011; words[1] = 32'h22334400;
    words[2] = 32'h00000055; words[3] = 32'h66778800;
    words[4] = 32'h00000099; words[5] = 32'hAAAAAAAA;
    words[6] = 32'hBBBBBBBB; words[7] = 32'hCCCCCCCC;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    do_reset();

    // Golden packet, back-to-back beats, with field-level checks
    load_golden();
    send_words(8, 16'h0001, 16'h0080);
    check("golden_dest_hw", 256'(packet_data.dest_addr.hw_addr), 256'(32'h11));
    check("golden_dest_sw", 256'(packet_data.dest_addr.sw_addr), 256'(16'h2233));
    check("golden_dest_port", 256'(packet_data.dest_addr.port), 256'(7'h22));
    check("golden_src_hw", 256'(packet_data.src_addr.hw_addr), 256'(32'h55));
    check("golden_src_sw", 256'(packet_data.src_addr.sw_addr), 256'(16'h6677));
    check("golden_src_port", 256'(packet_data.src_addr.port), 256'(7'h44));
    check("golden_lamport", 256'(packet_data.lamport), 256'(32'h99));
    check("golden_data", 256'(packet_data.data), 256'({32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}));
    check("golden_err_cnt", 256'(error_count), 256'(0));

    // Held output: ready stays low for 20 cycles without read_packet
    for (int i = 0; i < 20; i++) cycle();
    read_pkt();

    // Same packet with random valid gaps
    gaps = 1;
    send_words(8, 16'h0001, 16'h0080);
    check("gapped_data", 256'(packet_data), 256'(build(words[0], words[1], words[2], words[3],
                                                        words[4], words[5], words[6], words[7])));
    read_pkt();
    gaps = 0;

    // Early eop on beat 3, then a clean packet
    do_reset();
    send_words(4, 16'h0001, 16'h0008);
    check("early_eop_cnt", 256'(error_count), 256'(1));
    send_words(8, 16'h0001, 16'h0080);
    read_pkt();

    // sop on beat 5 restarts the frame there
    do_reset();
    for (int i = 0; i < 13; i++) words[i] = $urandom;
    send_words(13, 16'h0021, 16'h1000);
    check("restart_cnt", 256'(error_count), 256'(1));
    check("restart_valid", 256'(packet_valid), 256'(1));
    read_pkt();

    // Reset after beat 4, asserted asynchronously mid-cycle
    do_reset();
    load_golden();
    send_words(5, 16'h0001, 16'h0000);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    cycle();
    reset_n = 1'b1;
    cycle();
    send_beat(32'h12345678, 1'b0, 1'b1);
    check("no_sop_cnt", 256'(error_count), 256'(1));

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) send_beat($urandom, 1'b0, 1'b0);
    check("sat_cnt", 256'(error_count), 256'(255));

    // Mixed random traffic
    do_reset();
    gaps = 1;
    rand_read = 1;
    for (int k = 0; k < 200; k++) begin
      int kind = $urandom_range(0, 4);
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      if (kind <= 2) begin
        send_words(8, 16'h0001, 16'h0080);
      end else if (kind == 3) begin
        int n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++)
          send_beat(words[i], $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end else begin
        logic [15:0] sm = 16'h0001;
        logic [15:0] em = 16'h0080;
        int pos = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 0) sm[pos] = 1'b1;
        else em[pos] = ~em[pos];
        send_words(8, sm, em);
      end
    end
    rand_read = 0;
    read_packet = 1'b1;
    cycle();
    read_packet = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dircc_avalon_st_packet_receiver.md
DIRCC_AVALON_ST_PACKET_RECEIVER -- requirements
Module: dircc_avalon_st_packet_receiver

Interface
REQ-001 SHALL have parameter BITS_PER_SYMBOL, default 8, bits per Avalon-ST symbol.
REQ-002 SHALL have parameter SYMBOLS_PER_BEAT, default 4, symbols per beat; DATA_WIDTH = product (32), EMPTY_WIDTH = clog2(SYMBOLS_PER_BEAT).
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data  input  DATA_WIDTH  sink beat data.
REQ-006 SHALL have port empty  input  EMPTY_WIDTH  sink empty; ignored.
REQ-007 SHALL have port startofpacket  input  1  first beat marker.
REQ-008 SHALL have port endofpacket  input  1  last beat marker.
REQ-009 SHALL have port valid  input  1  sink beat valid.
REQ-010 SHALL have port ready  output  1  sink ready.
REQ-011 SHALL have port packet_data  output  packet_t  reassembled packet.
REQ-012 SHALL have port packet_valid  output  1  packet_data holds an unread packet.
REQ-013 SHALL have port read_packet  input  1  consumer acknowledge.
REQ-014 SHALL have port receiving  output  1  high when state != IDLE.
REQ-015 SHALL have port error  output  1  one-cycle pulse per framing error.
REQ-016 SHALL have port error_count  output  8  saturating framing-error count.

Function
REQ-017 A beat SHALL be accepted on a rising clk edge where valid && ready.
REQ-018 ready SHALL equal reset_n && !packet_valid (combinational; no beats accepted while output full).
REQ-019 States SHALL be IDLE, DEST_ADDR1, SRC_ADDR0, SRC_ADDR1, LAMPORT, DATA0, DATA1, DATA2, DISCARD; receiving = state != IDLE.
REQ-020 Beat order SHALL be: 0 dest_addr.hw_addr; 1 {dest sw_addr, port, flag} in [31:8]; 2 src_addr.hw_addr; 3 {src sw_addr, port, flag} in [31:8]; 4 lamport; 5 data[31:0]; 6 data[63:32]; 7 data[95:64]; bits [7:0] of beats 1 and 3 ignored.
REQ-021 IDLE: accepted beat with startofpacket captures beat 0 into a shadow packet and moves to DEST_ADDR1; beat without startofpacket is dropped, pulses error, stays IDLE.
REQ-022 Each capture state SHALL store its field and advance one state per accepted beat; no advance without acceptance.
REQ-023 DATA2: accepted beat with endofpacket SHALL store data[95:64], copy the complete shadow to packet_data, set packet_valid the next cycle (latency 1 cycle after eop beat), return to IDLE.
REQ-024 DATA2 beat without endofpacket SHALL pulse error, drop the packet, enter DISCARD.
REQ-025 DISCARD SHALL drop beats until an accepted endofpacket beat, then IDLE; startofpacket in DISCARD restarts as REQ-021.
REQ-026 endofpacket on any beat before DATA2 SHALL pulse error, drop the packet, return to IDLE (startofpacket+endofpacket single beat included).
REQ-027 startofpacket on any beat after beat 0 SHALL pulse error, discard the partial packet and capture this beat as beat 0 (state DEST_ADDR1).
REQ-028 packet_valid SHALL stay high with packet_data stable until a cycle with read_packet high; packet_valid clears the next cycle; read_packet while packet_valid low SHALL be ignored.
REQ-029 error_count SHALL increment once per error pulse and saturate at 255.
REQ-030 Simultaneous errors in one cycle SHALL count once.

Reset
REQ-031 While reset_n low: state IDLE, packet_valid 0, ready 0, receiving 0, error 0, error_count 0, packet_data all zero.
REQ-032 Reset mid-packet SHALL discard the partial packet; first packet after release requires startofpacket.

Structure
REQ-033 packet_t, address field types and beat count (8) SHALL come from dircc_types_pkg; beat-state enum local to module.
REQ-034 Single module; no sub-module.

Verification
REQ-035 Eight beats 0x00000011,0x22334400,0x00000055,0x66778800,0x00000099,0xAAAAAAAA,0xBBBBBBBB,0xCCCCCCCC with sop/eop -> packet_valid high 1 cycle after beat 7, fields match, error_count 0.
REQ-036 Valid deasserted randomly between beats -> identical packet_data to REQ-035.
REQ-037 Packet complete, read_packet held low 20 cycles -> ready 0 throughout; read_packet high 1 cycle -> packet_valid 0 and ready 1 next cycle.
REQ-038 eop on beat 3 -> error pulse, error_count 1, no packet_valid; following well-formed packet delivered correctly.
REQ-039 sop on beat 5 -> error_count 1, packet rebuilt from that beat onward, delivered after 7 more beats.
REQ-040 reset_n low after beat 4 -> all outputs at reset values; packet without sop after release dropped, error_count 1.
